// File: rtl/ucdp_clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
package ucdp_clk_div_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } hs_state_e;

  // Number of high cycles in a period of ratio r: ceil(r/2).
  function automatic logic [31:0] hi_cnt(input logic [31:0] r);
    return (r + 32'd1) >> 1;
  endfunction

endpackage

// File: rtl/ucdp_clk_mux.sv
// Clock select cell: clk_o = sel_i ? clkb_i : clka_i. Kept as one cell for clock constraints.
module ucdp_clk_mux (
  input  logic clka_i,
  input  logic clkb_i,
  input  logic sel_i,
  output logic clk_o
);

  assign clk_o = sel_i ? clkb_i : clka_i;

endmodule

// File: rtl/ucdp_clk_div.sv
// Programmable integer clock divider (R = div_i + 1, R = 1 is bypass) with glitch-free ratio switching.
// Optional output gating via en_i when UCDP_CLK_DIV_GATE_EN is defined.
module ucdp_clk_div #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned DEFAULT_DIV = 0
) (
  input  logic             clk_i,
  input  logic             rst_an_i,
  input  logic [WIDTH-1:0] div_i,
  input  logic             upd_i,
`ifdef UCDP_CLK_DIV_GATE_EN
  input  logic             en_i,
`endif
  output logic             busy_o,
  output logic             clk_en_o,
  output logic             clk_o
);
  import ucdp_clk_div_pkg::*;

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] ratio_q;
  logic [WIDTH-1:0] pend_q;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] ratio_next;
  logic [WIDTH:0]   r_next;
  logic [WIDTH:0]   hi_next;
  hs_state_e        state_q;
  logic             busy_q;
  logic             div_q;
  logic             clk_en_q;
  logic             en_q;
  logic             en_next;
  logic             boundary;
  logic             div_next;
  logic             bypass_q;
  logic             clk_b;

`ifdef UCDP_CLK_DIV_GATE_EN
  logic en_lat;

  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) en_q <= 1'b1;
    else           en_q <= en_next;
  end

  // Bypass path gate: enable only changes while clk_i is low.
  always_latch begin
    if (!rst_an_i)   en_lat = 1'b1;
    else if (!clk_i) en_lat = en_q;
  end

  assign clk_b = clk_i & en_lat;
`else
  assign en_q  = 1'b1;
  assign clk_b = clk_i;
`endif

  // A parked divider treats every cycle as a boundary so en_i and pending ratios are still sampled.
  always_comb begin
    boundary   = (cnt_q == ratio_q) || !en_q;
    ratio_next = ratio_q;
    en_next    = en_q;
    cnt_next   = cnt_q + WIDTH'(1);
    if (boundary) begin
      cnt_next = '0;
      if (state_q == PEND) ratio_next = pend_q;
`ifdef UCDP_CLK_DIV_GATE_EN
      en_next = en_i;
`endif
    end
    r_next   = {1'b0, ratio_next} + (WIDTH+1)'(1);
    hi_next  = (WIDTH+1)'(hi_cnt(32'(r_next)));
    div_next = en_next && ({1'b0, cnt_next} < hi_next);
  end

  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) begin
      cnt_q    <= '0;
      ratio_q  <= WIDTH'(DEFAULT_DIV);
      pend_q   <= WIDTH'(DEFAULT_DIV);
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      div_q    <= 1'b0;
      clk_en_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_next;
      ratio_q  <= ratio_next;
      div_q    <= div_next;
      clk_en_q <= en_next && (cnt_next == '0);
      case (state_q)
        IDLE: begin
          if (upd_i) begin
            pend_q  <= div_i;
            state_q <= PEND;
            busy_q  <= 1'b1;
          end
        end
        PEND: begin
          // A request landing on the boundary stays pending; the older one is applied.
          if (upd_i) begin
            pend_q <= div_i;
          end else if (boundary) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bypass_q = (ratio_q == '0);
  assign busy_o   = busy_q;
  assign clk_en_o = clk_en_q;

  ucdp_clk_mux u_clk_mux (
    .clka_i (div_q),
    .clkb_i (clk_b),
    .sel_i  (bypass_q),
    .clk_o  (clk_o)
  );

endmodule

// File: doc/ucdp_clk_div.md
Name: ucdp_clk_div

Overview:
Programmable integer clock divider with a glitch-free bypass mode. Produces clk_o = clk_i / R, where R = div_i + 1 and R = 1 means bypass.
- Ratio changes use a request/busy handshake and take effect only at a period boundary, so clk_o never shows a runt pulse.
- The final bypass/divided select reuses the existing ucdp_clk_mux.
- Sits in clock-generation subsystems ahead of peripheral clock trees.

Parameters:
- WIDTH, 4, ratio field width; R ranges 1..2**WIDTH.
- DEFAULT_DIV, 0, div value loaded at reset (0 = bypass).

Ports:
- clk_i  input  1  source clock.
- rst_an_i  input  1  asynchronous active-low reset.
- div_i  input  WIDTH  requested ratio minus one.
- upd_i  input  1  single-cycle request to load div_i.
- busy_o  output  1  a request is pending and not yet applied.
- clk_en_o  output  1  one-cycle pulse in the clk_i cycle that starts each clk_o period.
- clk_o  output  1  divided or bypassed clock.

Interface decision: one clock; reset is asynchronous and active-low (clk_i, rst_an_i).

Behaviour:
- State registers: cnt_q (WIDTH bits), ratio_q (WIDTH bits), pend_q (WIDTH bits), busy_q, div_q, en_q.
- Reset values: cnt_q = 0, ratio_q = DEFAULT_DIV, pend_q = DEFAULT_DIV, busy_o = 0, div_q = 0, clk_en_o = 0. clk_o follows clk_i if DEFAULT_DIV = 0, otherwise clk_o = 0.
- Counter: cnt_q counts 0..ratio_q and wraps to 0. The boundary is cnt_q == ratio_q. In bypass (ratio_q = 0) every cycle is a boundary.
- Duty cycle: div_q <= (cnt_next < ceil(R/2)), with R = ratio_q + 1, computed in WIDTH+1 bits so there is no overflow at R = 2**WIDTH.
  - R = 2: 1 high / 1 low.
  - R = 3: 2 high / 1 low.
  - R = 16: 8 high / 8 low.
- Output select: clk_o = bypass_q ? clk_i : div_q, where bypass_q = (ratio_q == 0).
- Glitch-freedom: bypass_q changes only at a boundary posedge, where both clk_i and the new div_q are high.
- clk_en_o: registered; high for exactly one clk_i cycle whenever cnt_q == 0. It is constant 1 in bypass.
- Handshake states, IDLE and PEND (busy_o = 1 in PEND):
  - IDLE: on upd_i, pend_q <= div_i and go to PEND.
  - PEND: at a boundary, ratio_q <= pend_q, cnt_q <= 0, go to IDLE. The new ratio governs the very next period.
- Simultaneous events: upd_i while in PEND overwrites pend_q; the last request wins and busy_o stays high. upd_i in the same cycle as a boundary applies the old pend_q; the new one stays pending.
- Same-ratio request: still goes through PEND and costs one period of latency. There is no phase disturbance, because cnt_q reaches the boundary naturally.
- Reset mid-period: clk_o drops or re-follows immediately (asynchronous); the pending request is discarded.
- Latency from upd_i to ratio_q updated: 1 cycle in bypass; at most R+1 cycles otherwise.

Optional Feature:
Macro: UCDP_CLK_DIV_GATE_EN.
- With the macro:
  - Extra input en_i (1 bit), sampled only at a boundary and held in en_q (reset value 1).
  - en_q = 0 parks clk_o low and clk_en_o low, and holds cnt_q at 0 after the boundary.
  - In bypass, gating uses a low-phase latch on en_q so the output stays glitch-free.
  - Re-enable starts a full high phase at the next posedge.
- Without the macro: no en_i port; the divider always runs.

Decomposition:
- Package ucdp_clk_div_pkg holds:
  - the handshake state enum (IDLE/PEND);
  - a helper function hi_cnt(R) returning ceil(R/2).
- Width-dependent types stay local to the module.
- Sub-module: instance of the existing ucdp_clk_mux for the final select (clka_i = div_q, clkb_i = clk_i, sel_i = bypass_q). This keeps the clock mux as a single cell for synthesis constraints.

Test Plan:
- Reset with DEFAULT_DIV = 0 -> clk_o tracks clk_i, busy_o = 0, clk_en_o = 1 every cycle.
- div_i = 3, upd_i pulse from bypass -> busy_o high for 1 cycle; then clk_o shows 2 high / 2 low periods and clk_en_o pulses every 4 cycles.
- R = 3 running, upd_i with div_i = 15 mid-period (cnt_q = 1) -> switch at the cnt_q = 2 boundary; then 8 high / 8 low; no pulse shorter than 1 clk_i cycle on clk_o.
- Two upd_i pulses (div_i = 5, then 1) within one R = 8 period -> only R = 2 is applied; busy_o stays high continuously until the boundary.
- Divided R = 4 -> bypass (div_i = 0) -> back to R = 5 -> check with a glitch monitor: clk_o has no high or low phase shorter than half a clk_i period at either switch.
- UCDP_CLK_DIV_GATE_EN: en_i = 0 mid-period at R = 4 -> clk_o completes its period, then stays low. en_i = 1 -> next period starts with 2 high cycles. Assert rst_an_i during gating -> en_q = 1 and output resumes per DEFAULT_DIV.
